kf8259_param_service_control: RTL and testbench

//  Clocked, parametrised interrupt-service controller for the KF8259 family: NUM_IRQ request lines, rotating priority,
//  in-service tracking, 8086 two-pulse INTA sequencer, poll mode, specific/non-specific/auto EOI.

---
 rtl/kf8259_param_pkg.sv | 14 +
 rtl/kf8259_param_service_control_if.sv | 35 +++
 rtl/kf8259_rot_priority_resolver.sv | 27 ++
 rtl/kf8259_param_service_control.sv | 88 ++++++++
 tb/tb_kf8259_param_service_control.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/kf8259_param_pkg.sv
// kf8259_param_pkg: FSM state codes and rotating-priority index helpers
package kf8259_param_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK1 = 2'd1;
  localparam logic [1:0] ST_ACK2 = 2'd2;
  localparam logic [1:0] ST_POLL = 2'd3;
  // n is always a power of two, so the modulo reduces to a mask
  function automatic int unsigned rot_idx(int unsigned base, int unsigned k, int unsigned n);
    return (base + k) & (n - 1);
  endfunction
  function automatic int unsigned rank_of(int unsigned id, int unsigned base, int unsigned n);
    return (id + n - base) & (n - 1);
  endfunction
endpackage

// File: rtl/kf8259_param_service_control_if.sv
// kf8259_param_service_control_if: CPU/IRR-side signal bundle of the service controller
interface kf8259_param_service_control_if #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ),
  parameter int VEC_W   = 8
);
  logic               init_pulse;
  logic [NUM_IRQ-1:0] irq_pending;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [VEC_W-1:0]   vector_base;
  logic               auto_eoi;
  logic               rotate_on_eoi;
  logic               eoi_write;
  logic               eoi_specific;
  logic [ID_W-1:0]    eoi_level;
  logic               poll_cmd;
  logic               inta_n;
  logic               read_n;
  logic               interrupt_to_cpu;
  logic [NUM_IRQ-1:0] clear_request;
  logic [NUM_IRQ-1:0] in_service;
  logic [VEC_W-1:0]   data_out;
  logic               data_out_enable;
  logic [ID_W-1:0]    priority_base;
  modport slave (
    input  init_pulse, irq_pending, irq_mask, vector_base, auto_eoi, rotate_on_eoi,
           eoi_write, eoi_specific, eoi_level, poll_cmd, inta_n, read_n,
    output interrupt_to_cpu, clear_request, in_service, data_out, data_out_enable, priority_base
  );
  modport master (
    output init_pulse, irq_pending, irq_mask, vector_base, auto_eoi, rotate_on_eoi,
           eoi_write, eoi_specific, eoi_level, poll_cmd, inta_n, read_n,
    input  interrupt_to_cpu, clear_request, in_service, data_out, data_out_enable, priority_base
  );
endinterface

// File: rtl/kf8259_rot_priority_resolver.sv
// kf8259_rot_priority_resolver: highest-rank set bit of i_req relative to rotating base
module kf8259_rot_priority_resolver
  import kf8259_param_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_base,
  output logic [ID_W-1:0]    o_id,
  output logic               o_valid
);
  logic [ID_W-1:0] w_idx;
  // scan from lowest rank up so the highest rank found is the last one written
  always_comb begin
    o_id = '0;
    o_valid = 1'b0;
    w_idx = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      w_idx = ID_W'(rot_idx(32'(i_base), k, NUM_IRQ));
      if (i_req[w_idx]) begin
        o_id = w_idx;
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/kf8259_param_service_control.sv
// kf8259_param_service_control: rotating-priority ISR tracking, INTA/poll sequencer and EOI handling
module kf8259_param_service_control
  import kf8259_param_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ),
  parameter int VEC_W   = 8
) (
  input logic clock,
  input logic reset_n,
  kf8259_param_service_control_if.slave bus
);
  logic [1:0] r_state, w_nxt;
  logic r_inta_q, r_read_q, r_int, r_doe, r_ack_v;
  logic [ID_W-1:0] r_ack_id, r_base, w_req_id, w_isr_id, w_eoi_id;
  logic [NUM_IRQ-1:0] r_isr, r_clr, w_set, w_clr;
  logic [VEC_W-1:0] r_dout, w_poll;
  logic w_req_v, w_isr_v, w_win_v, w_inta_fall, w_inta_rise, w_read_fall, w_read_rise;
  logic w_ack, w_pset, w_eoi_v, w_auto_v, w_unused;
  assign w_unused = ^bus.vector_base[ID_W-1:0];
  assign w_inta_fall = r_inta_q & ~bus.inta_n;
  assign w_inta_rise = ~r_inta_q & bus.inta_n;
  assign w_read_fall = r_read_q & ~bus.read_n;
  assign w_read_rise = ~r_read_q & bus.read_n;
  kf8259_rot_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_req (
    .i_req(bus.irq_pending & ~bus.irq_mask), .i_base(r_base), .o_id(w_req_id), .o_valid(w_req_v)
  );
  kf8259_rot_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr (
    .i_req(r_isr), .i_base(r_base), .o_id(w_isr_id), .o_valid(w_isr_v)
  );
  // fully nested: a request only wins if it outranks everything in service
  assign w_win_v = w_req_v & (~w_isr_v |
    (rank_of(32'(w_req_id), 32'(r_base), NUM_IRQ) < rank_of(32'(w_isr_id), 32'(r_base), NUM_IRQ)));
  assign w_nxt = (r_state == ST_IDLE) ? (w_inta_fall ? ST_ACK1 : bus.poll_cmd ? ST_POLL : ST_IDLE) :
                 (r_state == ST_POLL) ? (w_read_rise ? ST_IDLE : ST_POLL) :
                 w_inta_rise ? ((r_state == ST_ACK1) ? ST_ACK2 : ST_IDLE) : r_state;
  assign w_ack = (r_state == ST_IDLE) && w_inta_fall;
  assign w_pset = (r_state == ST_POLL) && w_read_fall && w_win_v;
  assign w_set = ((w_ack && w_win_v) || w_pset) ? NUM_IRQ'(1) << w_req_id : '0;
  assign w_eoi_id = bus.eoi_specific ? bus.eoi_level : w_isr_id;
  assign w_eoi_v = bus.eoi_write && (bus.eoi_specific ? r_isr[bus.eoi_level] : w_isr_v);
  assign w_auto_v = (r_state == ST_ACK2) && w_inta_rise && bus.auto_eoi && r_ack_v && r_isr[r_ack_id];
  assign w_clr = (w_eoi_v ? NUM_IRQ'(1) << w_eoi_id : '0) | (w_auto_v ? NUM_IRQ'(1) << r_ack_id : '0);
  always_comb begin
    w_poll = '0;
    w_poll[VEC_W-1] = w_win_v;
    w_poll[ID_W-1:0] = w_win_v ? w_req_id : '0;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_state <= ST_IDLE;
      {r_inta_q, r_read_q} <= 2'b11;
      {r_int, r_doe, r_ack_v} <= '0;
      {r_ack_id, r_base, r_isr, r_clr, r_dout} <= '0;
    end else if (bus.init_pulse) begin
      r_state <= ST_IDLE;
      {r_inta_q, r_read_q} <= 2'b11;
      {r_int, r_doe, r_ack_v} <= '0;
      {r_ack_id, r_base, r_isr, r_clr, r_dout} <= '0;
    end else begin
      r_inta_q <= bus.inta_n;
      r_read_q <= bus.read_n;
      r_state <= w_nxt;
      r_int <= (w_nxt == ST_IDLE) && w_win_v;
      r_isr <= (r_isr & ~w_clr) | w_set;
      r_clr <= w_set;
      r_base <= (w_auto_v && bus.rotate_on_eoi) ? r_ack_id + 1'b1 :
                (w_eoi_v && bus.rotate_on_eoi) ? w_eoi_id + 1'b1 : r_base;
      if (w_ack) begin
        r_ack_id <= w_win_v ? w_req_id : ID_W'(NUM_IRQ - 1);
        r_ack_v <= w_win_v;
      end
      if ((r_state == ST_ACK2) && w_inta_fall) begin
        r_dout <= {bus.vector_base[VEC_W-1:ID_W], r_ack_id};
        r_doe <= 1'b1;
      end else if ((r_state == ST_POLL) && w_read_fall) begin
        r_dout <= w_poll;
        r_doe <= 1'b1;
      end else if (((r_state == ST_ACK2) && w_inta_rise) || ((r_state == ST_POLL) && w_read_rise))
        r_doe <= 1'b0;
    end
  assign bus.interrupt_to_cpu = r_int;
  assign bus.clear_request = r_clr;
  assign bus.in_service = r_isr;
  assign bus.data_out = r_dout;
  assign bus.data_out_enable = r_doe;
  assign bus.priority_base = r_base;
endmodule

// File: tb/tb_kf8259_param_service_control.sv
// tb_kf8259_param_service_control: directed checks at NUM_IRQ=8 and NUM_IRQ=16
module tb_kf8259_param_service_control;
  logic clock, reset_n;
  int passed = 0, failed = 0, total = 0;
  kf8259_param_service_control_if #(.NUM_IRQ(8)) b8 ();
  kf8259_param_service_control_if #(.NUM_IRQ(16)) b16 ();
  kf8259_param_service_control #(.NUM_IRQ(8)) dut8 (.clock(clock), .reset_n(reset_n), .bus(b8));
  kf8259_param_service_control #(.NUM_IRQ(16)) dut16 (.clock(clock), .reset_n(reset_n), .bus(b16));
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset_n = 1'b0;
    {b8.init_pulse, b8.irq_pending, b8.irq_mask, b8.auto_eoi, b8.rotate_on_eoi} = '0;
    {b8.eoi_write, b8.eoi_specific, b8.eoi_level, b8.poll_cmd} = '0;
    {b8.inta_n, b8.read_n} = 2'b11;
    b8.vector_base = 8'h40;
    {b16.init_pulse, b16.irq_pending, b16.irq_mask, b16.auto_eoi, b16.rotate_on_eoi} = '0;
    {b16.eoi_write, b16.eoi_specific, b16.eoi_level, b16.poll_cmd} = '0;
    {b16.inta_n, b16.read_n} = 2'b11;
    b16.vector_base = 8'h40;
    tick();
    tick();
    chk("rst_int", 32'(b8.interrupt_to_cpu), 0);
    chk("rst_isr", 32'(b8.in_service), 0);
    chk("rst_doe", 32'(b8.data_out_enable), 0);
    chk("rst_dout", 32'(b8.data_out), 0);
    chk("rst_clr", 32'(b8.clear_request), 0);
    chk("rst_base", 32'(b8.priority_base), 0);
    reset_n = 1'b1;
    b8.irq_pending = 8'h24;
    tick();
    chk("int_024", 32'(b8.interrupt_to_cpu), 1);
    b8.inta_n = 1'b0;
    tick();
    chk("ack1_clr", 32'(b8.clear_request), 32'h04);
    chk("ack1_isr", 32'(b8.in_service), 32'h04);
    chk("ack1_int", 32'(b8.interrupt_to_cpu), 0);
    b8.irq_pending = 8'h20;
    tick();
    chk("clr_pulse", 32'(b8.clear_request), 0);
    b8.inta_n = 1'b1;
    tick();
    b8.inta_n = 1'b0;
    tick();
    chk("vec_42", 32'(b8.data_out), 32'h42);
    chk("vec_oe", 32'(b8.data_out_enable), 1);
    b8.inta_n = 1'b1;
    tick();
    chk("vec_oe_off", 32'(b8.data_out_enable), 0);
    chk("isr_kept", 32'(b8.in_service), 32'h04);
    b8.irq_pending = 8'h08;
    tick();
    tick();
    chk("nest_low", 32'(b8.interrupt_to_cpu), 0);
    b8.irq_pending = 8'h01;
    tick();
    chk("nest_high", 32'(b8.interrupt_to_cpu), 1);
    b8.irq_pending = 8'h00;
    b8.eoi_write = 1'b1;
    tick();
    b8.eoi_write = 1'b0;
    chk("ns_eoi_isr", 32'(b8.in_service), 0);
    chk("ns_eoi_base", 32'(b8.priority_base), 0);
    b8.inta_n = 1'b0;
    tick();
    chk("spur_isr", 32'(b8.in_service), 0);
    chk("spur_clr", 32'(b8.clear_request), 0);
    b8.inta_n = 1'b1;
    tick();
    b8.inta_n = 1'b0;
    tick();
    chk("spur_vec", 32'(b8.data_out), 32'h47);
    b8.inta_n = 1'b1;
    tick();
    b8.irq_pending = 8'h02;
    b8.irq_mask = 8'h02;
    tick();
    chk("masked_int", 32'(b8.interrupt_to_cpu), 0);
    b8.irq_mask = 8'h00;
    b8.irq_pending = 8'h08;
    b8.auto_eoi = 1'b1;
    b8.rotate_on_eoi = 1'b1;
    tick();
    chk("int_ir3", 32'(b8.interrupt_to_cpu), 1);
    b8.inta_n = 1'b0;
    tick();
    chk("aeoi_set", 32'(b8.in_service), 32'h08);
    b8.irq_pending = 8'h00;
    tick();
    b8.inta_n = 1'b1;
    tick();
    b8.irq_mask = 8'hFF;
    b8.inta_n = 1'b0;
    tick();
    chk("aeoi_vec", 32'(b8.data_out), 32'h43);
    b8.inta_n = 1'b1;
    tick();
    chk("aeoi_isr", 32'(b8.in_service), 0);
    chk("aeoi_base", 32'(b8.priority_base), 4);
    b8.auto_eoi = 1'b0;
    b8.irq_mask = 8'h00;
    b8.irq_pending = 8'h20;
    b8.poll_cmd = 1'b1;
    tick();
    b8.poll_cmd = 1'b0;
    b8.read_n = 1'b0;
    tick();
    chk("poll_word", 32'(b8.data_out), 32'h85);
    chk("poll_oe", 32'(b8.data_out_enable), 1);
    chk("poll_isr", 32'(b8.in_service), 32'h20);
    chk("poll_clr", 32'(b8.clear_request), 32'h20);
    b8.read_n = 1'b1;
    b8.irq_pending = 8'h00;
    tick();
    chk("poll_oe_off", 32'(b8.data_out_enable), 0);
    b8.eoi_write = 1'b1;
    b8.eoi_specific = 1'b1;
    b8.eoi_level = 3'd5;
    tick();
    {b8.eoi_write, b8.eoi_specific} = 2'b00;
    chk("seoi_isr", 32'(b8.in_service), 0);
    chk("seoi_base", 32'(b8.priority_base), 6);
    b8.rotate_on_eoi = 1'b0;
    b8.poll_cmd = 1'b1;
    tick();
    b8.poll_cmd = 1'b0;
    b8.read_n = 1'b0;
    tick();
    chk("poll_empty", 32'(b8.data_out), 0);
    chk("poll_empty_isr", 32'(b8.in_service), 0);
    b8.read_n = 1'b1;
    tick();
    b8.irq_pending = 8'h11;
    tick();
    b8.inta_n = 1'b0;
    tick();
    chk("rot_win", 32'(b8.in_service), 32'h01);
    b8.irq_pending = 8'h10;
    tick();
    b8.inta_n = 1'b1;
    tick();
    b8.inta_n = 1'b0;
    tick();
    chk("rot_vec", 32'(b8.data_out), 32'h40);
    reset_n = 1'b0;
    #1;
    chk("arst_oe", 32'(b8.data_out_enable), 0);
    chk("arst_isr", 32'(b8.in_service), 0);
    chk("arst_base", 32'(b8.priority_base), 0);
    reset_n = 1'b1;
    b8.inta_n = 1'b1;
    b8.irq_pending = 8'h24;
    tick();
    chk("arst_idle", 32'(b8.interrupt_to_cpu), 1);
    b8.inta_n = 1'b0;
    tick();
    b8.init_pulse = 1'b1;
    tick();
    chk("init_isr", 32'(b8.in_service), 0);
    chk("init_int", 32'(b8.interrupt_to_cpu), 0);
    b8.init_pulse = 1'b0;
    b8.inta_n = 1'b1;
    tick();
    chk("init_idle", 32'(b8.interrupt_to_cpu), 1);
    b16.irq_pending = 16'h0400;
    tick();
    chk("w16_int", 32'(b16.interrupt_to_cpu), 1);
    b16.inta_n = 1'b0;
    tick();
    chk("w16_isr", 32'(b16.in_service), 32'h0400);
    chk("w16_clr", 32'(b16.clear_request), 32'h0400);
    tick();
    b16.inta_n = 1'b1;
    tick();
    b16.inta_n = 1'b0;
    tick();
    chk("w16_vec", 32'(b16.data_out), 32'h4A);
    chk("w16_oe", 32'(b16.data_out_enable), 1);
    reset_n = 1'b0;
    #1;
    chk("w16_arst_oe", 32'(b16.data_out_enable), 0);
    chk("w16_arst_isr", 32'(b16.in_service), 0);
    reset_n = 1'b1;
    b16.inta_n = 1'b1;
    tick();
    chk("w16_idle", 32'(b16.interrupt_to_cpu), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
